// File: rtl/io_poller_pkg.sv
// Shared constants and enums for the io_poller bus initiator and its ALU.
package io_pkg;

  localparam logic [1:0] IO_ADDR_STATUS = 2'b00;
  localparam logic [1:0] IO_ADDR_LED    = 2'b01;
  localparam logic [1:0] IO_ADDR_SW_LO  = 2'b10;
  localparam logic [1:0] IO_ADDR_SW_HI  = 2'b11;

  localparam int STAT_IN_RDY  = 1;
  localparam int STAT_OUT_RDY = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POLL_IN,
    ST_GAP_IN,
    ST_READ_LO,
    ST_READ_HI,
    ST_COMPUTE,
    ST_POLL_OUT,
    ST_GAP_OUT,
    ST_WRITE,
    ST_FIN
  } poll_state_e;

endpackage

// File: rtl/io_poller_if.sv
// CPU-side bus between io_poller (master) and the switch/LED IO responder (slave).
interface io_poller_if;
  import io_pkg::*;

  logic        pRead;
  logic        pWrite;
  logic [1:0]  addr;
  logic [11:0] pWriteData;
  logic [31:0] pReadData;

  modport master (output pRead, pWrite, addr, pWriteData, input pReadData);
  modport slave  (input pRead, pWrite, addr, pWriteData, output pReadData);
endinterface

// File: rtl/io_poller_alu.sv
// Combinational 12-bit result from the two switch bytes; registered by io_poller in COMPUTE.
module io_alu
  import io_pkg::*;
(
  input  op_e         op,
  input  logic [7:0]  hi,
  input  logic [7:0]  lo,
  output logic [11:0] result
);

  logic signed [11:0] hi_s;
  logic signed [11:0] lo_s;
  logic signed [11:0] diff;
  logic [11:0]        prod;

  assign hi_s = signed'({4'b0000, hi});
  assign lo_s = signed'({4'b0000, lo});
  // 12-bit subtraction wraps naturally into two's complement
  assign diff = hi_s - lo_s;
  assign prod = 12'(hi) * 12'(lo);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = {3'b000, {1'b0, hi} + {1'b0, lo}};
      OP_SUB:  result = diff;
      OP_MUL:  result = prod;
      OP_PASS: result = {4'b0000, hi};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/io_poller.sv
// Polls IO status, reads both switch bytes, computes, polls LED readiness and writes the result.
// Optional bounded polling with timeout when IO_POLLER_TIMEOUT_EN is defined.
module io_poller
  import io_pkg::*;
#(
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  io_poller_if.master  bus,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [11:0]  result
);

`ifdef IO_POLLER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [15:0] GAP_LAST   = 16'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);

  poll_state_e state;
  op_e         op_q;
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic [15:0] gap_cnt;
  logic [15:0] poll_cnt;
  logic        timeout_q;
  logic        poll_expired;
  logic [11:0] alu_res;

  io_alu u_alu (
    .op     (op_q),
    .hi     (hi),
    .lo     (lo),
    .result (alu_res)
  );

  // The read in flight is the (poll_cnt+1)-th of this wait phase
  assign poll_expired = TO_EN && ((poll_cnt + 16'd1) >= POLL_LIMIT);
  assign timeout      = TO_EN ? timeout_q : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      op_q           <= OP_ADD;
      lo             <= '0;
      hi             <= '0;
      gap_cnt        <= '0;
      poll_cnt       <= '0;
      timeout_q      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      bus.pRead      <= 1'b0;
      bus.pWrite     <= 1'b0;
      bus.addr       <= IO_ADDR_STATUS;
      bus.pWriteData <= '0;
    end else begin
      // Strobes and done are single-cycle unless a transition re-asserts them
      bus.pRead  <= 1'b0;
      bus.pWrite <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op_e'(op);
            busy      <= 1'b1;
            timeout_q <= 1'b0;
            poll_cnt  <= '0;
            bus.pRead <= 1'b1;
            bus.addr  <= IO_ADDR_STATUS;
            state     <= ST_POLL_IN;
          end
        end
        ST_POLL_IN: begin
          poll_cnt <= poll_cnt + 16'd1;
          if (bus.pReadData[STAT_IN_RDY]) begin
            bus.pRead <= 1'b1;
            bus.addr  <= IO_ADDR_SW_LO;
            state     <= ST_READ_LO;
          end else if (poll_expired) begin
            timeout_q <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_FIN;
          end else if (POLL_GAP == 0) begin
            bus.pRead <= 1'b1;
          end else begin
            gap_cnt <= '0;
            state   <= ST_GAP_IN;
          end
        end
        ST_GAP_IN: begin
          if (gap_cnt == GAP_LAST) begin
            bus.pRead <= 1'b1;
            state     <= ST_POLL_IN;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        ST_READ_LO: begin
          lo        <= bus.pReadData[7:0];
          bus.pRead <= 1'b1;
          bus.addr  <= IO_ADDR_SW_HI;
          state     <= ST_READ_HI;
        end
        ST_READ_HI: begin
          hi    <= bus.pReadData[7:0];
          state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          result    <= alu_res;
          poll_cnt  <= '0;
          bus.pRead <= 1'b1;
          bus.addr  <= IO_ADDR_STATUS;
          state     <= ST_POLL_OUT;
        end
        ST_POLL_OUT: begin
          poll_cnt <= poll_cnt + 16'd1;
          if (bus.pReadData[STAT_OUT_RDY]) begin
            bus.pWrite     <= 1'b1;
            bus.addr       <= IO_ADDR_LED;
            bus.pWriteData <= result;
            state          <= ST_WRITE;
          end else if (poll_expired) begin
            timeout_q <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_FIN;
          end else if (POLL_GAP == 0) begin
            bus.pRead <= 1'b1;
          end else begin
            gap_cnt <= '0;
            state   <= ST_GAP_OUT;
          end
        end
        ST_GAP_OUT: begin
          if (gap_cnt == GAP_LAST) begin
            bus.pRead <= 1'b1;
            state     <= ST_POLL_OUT;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        ST_WRITE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_poller.sv
// Randomized bench for io_poller with an IO responder and a transaction-level reference model.
module tb_io_poller;

  localparam int G    = 4;
  localparam int MAXP = 8;
`ifdef IO_POLLER_TIMEOUT_EN
  localparam bit TOEN = 1'b1;
`else
  localparam bit TOEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        busy, done, timeout;
  logic [11:0] result;

  io_poller_if bus ();

  io_poller #(.POLL_GAP(G), .MAX_POLLS(MAXP)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .result  (result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // IO responder: status readiness released after a scripted number of polls
  logic [15:0] sw;
  logic [31:0] junk;
  int          n_in, n_out, base;
  int          st_reads = 0;
  int          k_rel;
  logic        in_r, out_r;

  always @(posedge clk) if (bus.pRead && bus.addr == 2'b00) st_reads <= st_reads + 1;

  always_comb begin
    k_rel = st_reads - base;
    in_r  = (k_rel >= n_in);
    out_r = (k_rel >= n_in + 1 + n_out);
    bus.pReadData = junk;
    case (bus.addr)
      2'b00:   bus.pReadData = {junk[31:2], in_r, out_r};
      2'b10:   bus.pReadData = {junk[31:8], sw[7:0]};
      2'b11:   bus.pReadData = {junk[31:8], sw[15:8]};
      default: bus.pReadData = junk;
    endcase
  end

  // Bus monitor
  int          rd_cyc[$];
  logic [1:0]  rd_addr[$];
  int          wr_cyc[$];
  logic [1:0]  wr_addr[$];
  logic [11:0] wr_data[$];
  int          done_cyc[$];
  int          both_hi = 0;

  always @(negedge clk) begin
    if (bus.pRead) begin rd_cyc.push_back(cyc); rd_addr.push_back(bus.addr); end
    if (bus.pWrite) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(bus.addr); wr_data.push_back(bus.pWriteData);
    end
    if (done) done_cyc.push_back(cyc);
    if (bus.pRead && bus.pWrite) both_hi <= both_hi + 1;
  end

  logic [11:0] prev_res = '0;

  function automatic logic [11:0] model(input logic [1:0] o, input logic [15:0] s);
    int hi = int'(s[15:8]);
    int lo = int'(s[7:0]);
    case (o)
      2'd0:    return 12'(hi + lo);
      2'd1:    return 12'((hi - lo) & 32'hFFF);
      2'd2:    return 12'((hi * lo) % 4096);
      default: return 12'(hi);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input logic [1:0] o, input logic [15:0] s, input int ni, input int no,
                     input int poke);
    int rb, wb, db, sc, n, ip, op_cnt, sp_bad, ok;
    bit to_in, to_out;
    int exp_done;
    logic [11:0] exp_res;
    to_in  = TOEN && (ni >= MAXP);
    to_out = TOEN && !to_in && (no >= MAXP);
    sw = s; n_in = ni; n_out = no; junk = $urandom; base = st_reads;
    rb = rd_cyc.size(); wb = wr_cyc.size(); db = done_cyc.size();
    start = 1'b1; op = o; sc = cyc;
    tick;
    start = 1'b0; op = 2'($urandom);
    check("busy_rise", busy, 1);
    check("timeout_clr", timeout, 0);
    n = 0;
    while (done_cyc.size() == db && n < 3000) begin
      if (n == poke) begin start = 1'b1; op = 2'b10; end else start = 1'b0;
      tick;
      n++;
    end
    start = 1'b0;
    if (done_cyc.size() == db) begin
      check("done_seen", done_cyc.size() - db, 1);
      return;
    end
    exp_res  = to_in ? prev_res : model(o, s);
    exp_done = to_in  ? 2 + (MAXP - 1) * (G + 1) :
               to_out ? 6 + ni * (G + 1) + (MAXP - 1) * (G + 1) :
                        7 + (ni + no) * (G + 1);
    check("done_lat", done_cyc[db] - sc, exp_done);
    check("busy_fin", busy, 0);
    check("done_fin", done, 1);
    check("result", result, exp_res);
    check("timeout", timeout, (to_in || to_out) ? 1 : 0);
    check("wr_count", wr_cyc.size() - wb, (to_in || to_out) ? 0 : 1);
    if (wr_cyc.size() > wb) begin
      check("wr_data", wr_data[wb], exp_res);
      check("wr_addr", wr_addr[wb], 2'b01);
      check("wr_lat", wr_cyc[wb] - sc, exp_done - 1);
    end
    // input-phase polls: count and spacing
    ip = 0; sp_bad = 0;
    while (rb + ip < rd_cyc.size() && rd_addr[rb + ip] == 2'b00) begin
      if (ip > 0 && rd_cyc[rb + ip] - rd_cyc[rb + ip - 1] != G + 1) sp_bad++;
      ip++;
    end
    check("in_polls", ip, to_in ? MAXP : ni + 1);
    check("poll_gap", sp_bad, 0);
    if (rd_cyc.size() > rb) check("first_poll", rd_cyc[rb] - sc, 1);
    if (!to_in) begin
      ok = (rd_cyc.size() > rb + ip + 1) ? 1 : 0;
      if (ok == 1) ok = (rd_addr[rb + ip] == 2'b10 && rd_addr[rb + ip + 1] == 2'b11 &&
                         rd_cyc[rb + ip + 1] - rd_cyc[rb + ip] == 1) ? 1 : 0;
      check("sw_reads", ok, 1);
      op_cnt = 0;
      for (int i = rb + ip + 2; i < rd_cyc.size(); i++) if (rd_addr[i] == 2'b00) op_cnt++;
      check("out_polls", op_cnt, to_out ? MAXP : no + 1);
    end
    prev_res = exp_res;
    if (poke >= 0) begin
      repeat (15) tick;
      check("no_2nd_done", done_cyc.size() - db, 1);
      check("no_2nd_write", wr_cyc.size() - wb, 1);
    end
  endtask

  int rs_wb, rs_db, rs_sc;

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00;
    sw = '0; junk = '0; n_in = 0; n_out = 0; base = 0;
    repeat (3) tick;
    check("rst_pRead", bus.pRead, 0);
    check("rst_pWrite", bus.pWrite, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.pWriteData, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_result", result, 0);
    reset = 1'b1;
    tick;

    run(2'b00, 16'h0305, 0, 0, -1);
    tick; run(2'($urandom), 16'($urandom), 3, 0, -1);
    tick; run(2'b01, 16'h02FF, 0, 1, -1);
    tick; run(2'b10, 16'hFFFF, 1, 2, -1);
    tick; run(2'b11, 16'hAB00, 0, 0, 3);

    // start during FIN is dropped; start in the following IDLE cycle is taken
    tick; run(2'b00, 16'h1122, 0, 0, -1);
    start = 1'b1; op = 2'b00;
    tick;
    start = 1'b0;
    check("fin_start_ign", busy, 0);
    run(2'b01, 16'($urandom), 0, 0, -1);

    for (int t = 0; t < 10; t++) begin
      tick;
      run(2'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // long waits: bounded by MAX_POLLS only when the timeout option is built in
    tick; run(2'($urandom), 16'($urandom), 9, 0, -1);
    tick; run(2'($urandom), 16'($urandom), 0, 10, -1);
    tick; run(2'($urandom), 16'($urandom), 0, 0, -1);

    // asynchronous reset during POLL_OUT
    tick;
    sw = 16'($urandom); n_in = 0; n_out = 100000; junk = $urandom; base = st_reads;
    rs_wb = wr_cyc.size(); rs_db = done_cyc.size();
    start = 1'b1; op = 2'b00; rs_sc = cyc;
    tick;
    start = 1'b0;
    while (cyc < rs_sc + 5) tick;
    check("po_pRead", bus.pRead, 1);
    check("po_addr", bus.addr, 0);
    #1 reset = 1'b0;
    #1;
    check("ar_pRead", bus.pRead, 0);
    check("ar_pWrite", bus.pWrite, 0);
    check("ar_addr", bus.addr, 0);
    check("ar_wdata", bus.pWriteData, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_result", result, 0);
    check("ar_timeout", timeout, 0);
    tick;
    reset = 1'b1;
    repeat (8) tick;
    check("ar_no_write", wr_cyc.size() - rs_wb, 0);
    check("ar_no_done", done_cyc.size() - rs_db, 0);
    check("ar_idle", busy, 0);
    prev_res = '0;
    run(2'b10, 16'($urandom), 1, 1, -1);

    check("strobe_excl", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
